// File: rtl/axi_rd_arb_pkg.sv
// axi_rd_arb_pkg: shared FSM encoding, ARID layout, RRESP codes and burst-count rule for axi_rd_arb
package axi_rd_arb_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
  localparam logic [1:0] RRESP_OKAY = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  function automatic int idx_w(input int nreq);
    return (nreq < 2) ? 1 : $clog2(nreq);
  endfunction
  function automatic int seq_w(input int id_w, input int nreq);
    return id_w - idx_w(nreq);
  endfunction
  // A burst count of zero still occupies one outstanding slot
  function automatic logic [3:0] eff_num(input logic [3:0] num);
    return (num == 4'd0) ? 4'd1 : num;
  endfunction
endpackage

// File: rtl/axi_rd_arb_rr_arbiter.sv
// axi_rd_arb_rr_arbiter: round-robin pick of the first request at or after ptr
module axi_rd_arb_rr_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);
  logic [IW-1:0] j;
  // Walk the offsets from farthest to nearest so the nearest hit wins
  always_comb begin
    gnt_o = '0;
    gnt_idx_o = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (req_i[j]) begin
        gnt_o = N'(1) << j;
        gnt_idx_o = j;
      end
    end
  end
endmodule

// File: rtl/axi_rd_arb.sv
// axi_rd_arb: round-robin AXI read-request arbiter with per-requester outstanding budget and RID routing
module axi_rd_arb
  import axi_rd_arb_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int ARID_WIDTH   = 4,
  parameter int ARADDR_WIDTH = 10,
  parameter int RDATA_WIDTH  = 64,
  parameter int MAX_OUTST    = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req_arvld,
  output logic [NREQ-1:0]              req_arrdy,
  input  logic [NREQ*ARADDR_WIDTH-1:0] req_araddr,
  input  logic [NREQ*8-1:0]            req_arlen,
  input  logic [NREQ*3-1:0]            req_arsize,
  input  logic [NREQ*2-1:0]            req_arburst,
  input  logic [NREQ*3-1:0]            req_arstr,
  input  logic [NREQ*4-1:0]            req_arnum,
  output logic [NREQ-1:0]              req_rvld,
  input  logic [NREQ-1:0]              req_rrdy,
  output logic [RDATA_WIDTH-1:0]       req_rdata,
  output logic [1:0]                   req_rresp,
  output logic                         req_rlast,
  output logic [ARID_WIDTH-1:0]        lsu_axi_arid,
  output logic [ARADDR_WIDTH-1:0]      lsu_axi_araddr,
  output logic [7:0]                   lsu_axi_arlen,
  output logic [2:0]                   lsu_axi_arsize,
  output logic [1:0]                   lsu_axi_arburst,
  output logic [2:0]                   lsu_axi_arstr,
  output logic [3:0]                   lsu_axi_arnum,
  output logic                         lsu_axi_arvld,
  input  logic                         axi_lsu_arrdy,
  input  logic [ARID_WIDTH-1:0]        axi_lsu_rid,
  input  logic [RDATA_WIDTH-1:0]       axi_lsu_rdata,
  input  logic [1:0]                   axi_lsu_rresp,
  input  logic                         axi_lsu_rlast,
  input  logic                         axi_lsu_rvld,
  output logic                         lsu_axi_rrdy,
  output logic                         arb_err
);
  localparam int IDX_W = idx_w(NREQ);
  localparam int SEQ_W = seq_w(ARID_WIDTH, NREQ);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int SW = ((OW > 4) ? OW : 4) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [IDX_W:0] NREQ_L = (IDX_W + 1)'(NREQ);

  state_e state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, win_q, gnt_idx, rid_idx;
  logic [SEQ_W-1:0] seq_q [NREQ];
  logic [OW-1:0] outst_q [NREQ];
  logic [OW-1:0] outst_d [NREQ];
  logic [NREQ-1:0] elig, gnt;
  logic [ARID_WIDTH-1:0] arid_q;
  logic [ARADDR_WIDTH-1:0] araddr_q;
  logic [7:0] arlen_q;
  logic [2:0] arsize_q, arstr_q;
  logic [1:0] arburst_q;
  logic [3:0] arnum_q;
  logic err_q, err_d, grant, accept, bad, beat_last, unused_seq;

  assign rid_idx = axi_lsu_rid[ARID_WIDTH-1 -: IDX_W];
  assign unused_seq = ^axi_lsu_rid[SEQ_W-1:0];
  assign bad = {1'b0, rid_idx} >= NREQ_L;
  assign grant = (state_q == IDLE) && (|elig);
  assign accept = (state_q == BUSY) && axi_lsu_arrdy;
  assign beat_last = axi_lsu_rvld & lsu_axi_rrdy & axi_lsu_rlast & ~bad;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++)
      elig[i] = req_arvld[i] &&
                (SW'(outst_q[i]) + SW'(eff_num(req_arnum[i*4 +: 4])) <= SW'(MAX_OUTST));
  end

  axi_rd_arb_rr_arbiter #(.N(NREQ), .IW(IDX_W)) u_rr (
    .req_i    (elig),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;

  always_comb
    state_d = (state_q == IDLE) ? ((|elig) ? BUSY : IDLE) : (axi_lsu_arrdy ? IDLE : BUSY);

  // Grant pulse is masked while reset is held so nothing is acknowledged during reset
  always_comb begin
    lsu_axi_arvld = state_q == BUSY;
    req_arrdy = (state_q == IDLE && rst_n) ? gnt : '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      win_q <= '0;
      arid_q <= '0;
      araddr_q <= '0;
      arlen_q <= '0;
      arsize_q <= '0;
      arburst_q <= '0;
      arstr_q <= '0;
      arnum_q <= '0;
    end else if (grant) begin
      win_q <= gnt_idx;
      arid_q <= {gnt_idx, seq_q[gnt_idx]};
      araddr_q <= req_araddr[gnt_idx*ARADDR_WIDTH +: ARADDR_WIDTH];
      arlen_q <= req_arlen[gnt_idx*8 +: 8];
      arsize_q <= req_arsize[gnt_idx*3 +: 3];
      arburst_q <= req_arburst[gnt_idx*2 +: 2];
      arstr_q <= req_arstr[gnt_idx*3 +: 3];
      arnum_q <= req_arnum[gnt_idx*4 +: 4];
    end

  assign ptr_d = accept ? ((win_q == LAST_IDX) ? '0 : win_q + 1'b1) : ptr_q;

  // Increment on downstream accept and decrement on a last beat may hit the same counter
  always_comb begin
    err_d = err_q | (axi_lsu_rvld & bad);
    for (int i = 0; i < NREQ; i++) begin
      outst_d[i] = outst_q[i]
                 + ((accept && win_q == IDX_W'(i)) ? OW'(eff_num(arnum_q)) : '0)
                 - ((beat_last && rid_idx == IDX_W'(i) && outst_q[i] != '0) ? OW'(1) : '0);
      if (beat_last && rid_idx == IDX_W'(i) && outst_q[i] == '0) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        seq_q[i] <= '0;
        outst_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
      for (int i = 0; i < NREQ; i++) begin
        outst_q[i] <= outst_d[i];
        if (accept && win_q == IDX_W'(i)) seq_q[i] <= seq_q[i] + 1'b1;
      end
    end

  always_comb begin
    req_rvld = '0;
    if (!bad) req_rvld[rid_idx] = axi_lsu_rvld;
    lsu_axi_rrdy = bad ? 1'b1 : req_rrdy[rid_idx];
  end

  assign req_rdata = axi_lsu_rdata;
  assign req_rresp = axi_lsu_rresp;
  assign req_rlast = axi_lsu_rlast;
  assign lsu_axi_arid = arid_q;
  assign lsu_axi_araddr = araddr_q;
  assign lsu_axi_arlen = arlen_q;
  assign lsu_axi_arsize = arsize_q;
  assign lsu_axi_arburst = arburst_q;
  assign lsu_axi_arstr = arstr_q;
  assign lsu_axi_arnum = arnum_q;
  assign arb_err = err_q;
endmodule

// File: tb/tb_axi_rd_arb.sv
// tb_axi_rd_arb: directed and randomized checks of axi_rd_arb against a behavioural model
module tb_axi_rd_arb;
  localparam int NREQ = 2, AW = 10, DW = 64, IDW = 4, MAXO = 15, SEQ_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0] req_arvld, req_arrdy, req_rvld, req_rrdy;
  logic [NREQ*AW-1:0] req_araddr;
  logic [NREQ*8-1:0] req_arlen;
  logic [NREQ*3-1:0] req_arsize, req_arstr;
  logic [NREQ*2-1:0] req_arburst;
  logic [NREQ*4-1:0] req_arnum;
  logic [DW-1:0] req_rdata, axi_lsu_rdata;
  logic [1:0] req_rresp, axi_lsu_rresp, lsu_axi_arburst;
  logic req_rlast, lsu_axi_arvld, axi_lsu_arrdy, axi_lsu_rlast, axi_lsu_rvld, lsu_axi_rrdy, arb_err;
  logic [IDW-1:0] lsu_axi_arid, axi_lsu_rid;
  logic [AW-1:0] lsu_axi_araddr;
  logic [7:0] lsu_axi_arlen;
  logic [2:0] lsu_axi_arsize, lsu_axi_arstr;
  logic [3:0] lsu_axi_arnum;

  axi_rd_arb #(.NREQ(NREQ), .ARID_WIDTH(IDW), .ARADDR_WIDTH(AW), .RDATA_WIDTH(DW), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_arvld(req_arvld), .req_arrdy(req_arrdy), .req_araddr(req_araddr), .req_arlen(req_arlen),
    .req_arsize(req_arsize), .req_arburst(req_arburst), .req_arstr(req_arstr), .req_arnum(req_arnum),
    .req_rvld(req_rvld), .req_rrdy(req_rrdy), .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rlast(req_rlast),
    .lsu_axi_arid(lsu_axi_arid), .lsu_axi_araddr(lsu_axi_araddr), .lsu_axi_arlen(lsu_axi_arlen),
    .lsu_axi_arsize(lsu_axi_arsize), .lsu_axi_arburst(lsu_axi_arburst), .lsu_axi_arstr(lsu_axi_arstr),
    .lsu_axi_arnum(lsu_axi_arnum), .lsu_axi_arvld(lsu_axi_arvld), .axi_lsu_arrdy(axi_lsu_arrdy),
    .axi_lsu_rid(axi_lsu_rid), .axi_lsu_rdata(axi_lsu_rdata), .axi_lsu_rresp(axi_lsu_rresp),
    .axi_lsu_rlast(axi_lsu_rlast), .axi_lsu_rvld(axi_lsu_rvld), .lsu_axi_rrdy(lsu_axi_rrdy), .arb_err(arb_err)
  );

  // Three-requester instance: the only configuration where an RID index can be out of range
  logic [2:0] d3_arvld, d3_arrdy, d3_rvld, d3_rrdy;
  logic [29:0] d3_araddr;
  logic [23:0] d3_arlen;
  logic [8:0] d3_arsize, d3_arstr;
  logic [5:0] d3_arburst;
  logic [11:0] d3_arnum;
  logic [DW-1:0] d3_rdata;
  logic [1:0] d3_rresp, d3_o_arburst;
  logic d3_rlast, d3_o_arvld, d3_i_rlast, d3_i_rvld, d3_o_rrdy, d3_err;
  logic [IDW-1:0] d3_o_arid, d3_i_rid;
  logic [AW-1:0] d3_o_araddr;
  logic [7:0] d3_o_arlen;
  logic [2:0] d3_o_arsize, d3_o_arstr;
  logic [3:0] d3_o_arnum;

  axi_rd_arb #(.NREQ(3), .ARID_WIDTH(IDW), .ARADDR_WIDTH(AW), .RDATA_WIDTH(DW), .MAX_OUTST(MAXO)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_arvld(d3_arvld), .req_arrdy(d3_arrdy), .req_araddr(d3_araddr), .req_arlen(d3_arlen),
    .req_arsize(d3_arsize), .req_arburst(d3_arburst), .req_arstr(d3_arstr), .req_arnum(d3_arnum),
    .req_rvld(d3_rvld), .req_rrdy(d3_rrdy), .req_rdata(d3_rdata), .req_rresp(d3_rresp), .req_rlast(d3_rlast),
    .lsu_axi_arid(d3_o_arid), .lsu_axi_araddr(d3_o_araddr), .lsu_axi_arlen(d3_o_arlen),
    .lsu_axi_arsize(d3_o_arsize), .lsu_axi_arburst(d3_o_arburst), .lsu_axi_arstr(d3_o_arstr),
    .lsu_axi_arnum(d3_o_arnum), .lsu_axi_arvld(d3_o_arvld), .axi_lsu_arrdy(1'b1),
    .axi_lsu_rid(d3_i_rid), .axi_lsu_rdata(64'h0), .axi_lsu_rresp(2'b00),
    .axi_lsu_rlast(d3_i_rlast), .axi_lsu_rvld(d3_i_rvld), .lsu_axi_rrdy(d3_o_rrdy), .arb_err(d3_err)
  );

  int nchk = 0, nerr = 0;
  int m_busy, m_ptr, m_win;
  int m_seq [NREQ];
  int m_outst [NREQ];
  logic m_err;
  logic [IDW-1:0] m_arid;
  logic [29:0] m_pay;
  logic [NREQ-1:0] last_rdy, o_rdy, o_rvld;
  logic o_rrdy;
  logic [IDW-1:0] t2_ids [$];
  logic [IDW-1:0] t2_exp [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff(input logic [3:0] n);
    return (n == 4'd0) ? 1 : int'(n);
  endfunction

  // Model: first eligible requester scanning forward from the round-robin pointer
  function automatic int pick();
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (req_arvld[j] && m_outst[j] + eff(req_arnum[j*4 +: 4]) <= MAXO) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_win = 0; m_err = 1'b0; m_arid = '0; m_pay = '0;
    for (int i = 0; i < NREQ; i++) begin
      m_seq[i] = 0;
      m_outst[i] = 0;
    end
  endtask

  task automatic zero_inputs();
    req_arvld = '0; req_araddr = '0; req_arlen = '0; req_arsize = '0; req_arburst = '0;
    req_arstr = '0; req_arnum = '0; req_rrdy = '0; axi_lsu_arrdy = 1'b0; axi_lsu_rid = '0;
    axi_lsu_rdata = '0; axi_lsu_rresp = '0; axi_lsu_rlast = 1'b0; axi_lsu_rvld = 1'b0;
    d3_arvld = '0; d3_araddr = '0; d3_arlen = '0; d3_arsize = '0; d3_arburst = '0; d3_arstr = '0;
    d3_arnum = '0; d3_rrdy = '0; d3_i_rid = '0; d3_i_rlast = 1'b0; d3_i_rvld = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    zero_inputs();
    model_reset();
    last_rdy = '0;
    @(negedge clk);
    chk("rst_arvld", 64'(lsu_axi_arvld), 64'(0));
    chk("rst_arrdy", 64'(req_arrdy), 64'(0));
    chk("rst_arid", 64'(lsu_axi_arid), 64'(0));
    chk("rst_payload", 64'({lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize, lsu_axi_arburst,
                            lsu_axi_arstr, lsu_axi_arnum}), 64'(0));
    chk("rst_err", 64'(arb_err), 64'(0));
    for (int i = 0; i < NREQ; i++) chk("rst_outst", 64'(dut.outst_q[i]), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [3:0] n);
    req_araddr[i*AW +: AW] = a;
    req_arlen[i*8 +: 8] = 8'(a);
    req_arsize[i*3 +: 3] = 3'(i + 2);
    req_arburst[i*2 +: 2] = 2'b01;
    req_arstr[i*3 +: 3] = 3'(n);
    req_arnum[i*4 +: 4] = n;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs
  task automatic cyc();
    int w, idx;
    logic bad, exp_rrdy;
    logic [NREQ-1:0] exp_rdy, exp_rvld;
    int old [NREQ];
    #1;
    w = m_busy ? -1 : pick();
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    idx = int'(axi_lsu_rid) >> SEQ_W;
    bad = idx >= NREQ;
    exp_rvld = '0;
    if (!bad && axi_lsu_rvld) exp_rvld[idx] = 1'b1;
    exp_rrdy = bad ? 1'b1 : req_rrdy[idx];
    o_rdy = req_arrdy; o_rvld = req_rvld; o_rrdy = lsu_axi_rrdy;
    chk("arrdy", 64'(req_arrdy), 64'(exp_rdy));
    chk("rvld", 64'(req_rvld), 64'(exp_rvld));
    chk("rrdy", 64'(lsu_axi_rrdy), 64'(exp_rrdy));
    chk("rdata", req_rdata, axi_lsu_rdata);
    chk("rresp_rlast", 64'({req_rresp, req_rlast}), 64'({axi_lsu_rresp, axi_lsu_rlast}));
    old = m_outst;
    if (w >= 0) begin
      m_busy = 1; m_win = w;
      m_arid = IDW'((w << SEQ_W) | m_seq[w]);
      m_pay = {req_araddr[w*AW +: AW], req_arlen[w*8 +: 8], req_arsize[w*3 +: 3],
               req_arburst[w*2 +: 2], req_arstr[w*3 +: 3], req_arnum[w*4 +: 4]};
    end else if (m_busy != 0 && axi_lsu_arrdy) begin
      m_busy = 0;
      m_ptr = (m_win + 1) % NREQ;
      m_seq[m_win] = (m_seq[m_win] + 1) % (1 << SEQ_W);
      m_outst[m_win] += eff(m_pay[3:0]);
    end
    if (axi_lsu_rvld && bad) m_err = 1'b1;
    else if (axi_lsu_rvld && exp_rrdy && axi_lsu_rlast) begin
      if (old[idx] == 0) m_err = 1'b1;
      else m_outst[idx]--;
    end
    last_rdy = exp_rdy;
    @(posedge clk);
    #1;
    chk("arvld", 64'(lsu_axi_arvld), 64'(m_busy));
    if (m_busy != 0) begin
      chk("arid", 64'(lsu_axi_arid), 64'(m_arid));
      chk("payload", 64'({lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize, lsu_axi_arburst,
                          lsu_axi_arstr, lsu_axi_arnum}), 64'(m_pay));
    end
    chk("err", 64'(arb_err), 64'(m_err));
    for (int i = 0; i < NREQ; i++) chk("outst", 64'(dut.outst_q[i]), 64'(m_outst[i]));
    @(negedge clk);
  endtask

  initial begin
    t2_exp[0] = 4'h0; t2_exp[1] = 4'h8; t2_exp[2] = 4'h1; t2_exp[3] = 4'h9;
    do_reset();

    // Single grant
    set_req(0, 10'h040, 4'd2);
    req_arvld = 2'b01;
    cyc();
    chk("t1_grant", 64'(o_rdy), 64'(2'b01));
    chk("t1_arvld", 64'(lsu_axi_arvld), 64'(1));
    chk("t1_arid", 64'(lsu_axi_arid), 64'(4'h0));
    chk("t1_araddr", 64'(lsu_axi_araddr), 64'(10'h040));
    req_arvld = '0;
    axi_lsu_arrdy = 1'b1;
    cyc();
    chk("t1_outst", 64'(dut.outst_q[0]), 64'(2));

    // Round-robin fairness
    do_reset();
    set_req(0, 10'h100, 4'd1);
    set_req(1, 10'h200, 4'd1);
    req_arvld = 2'b11;
    axi_lsu_arrdy = 1'b1;
    for (int n = 0; n < 8; n++) begin
      cyc();
      if (lsu_axi_arvld) t2_ids.push_back(lsu_axi_arid);
    end
    chk("t2_count", 64'(t2_ids.size()), 64'(4));
    for (int i = 0; i < 4; i++)
      chk("t2_arid", 64'((i < t2_ids.size()) ? t2_ids[i] : 4'hx), 64'(t2_exp[i]));

    // Backpressure: payload held, no further grants
    axi_lsu_arrdy = 1'b0;
    cyc();
    for (int n = 0; n < 5; n++) begin
      cyc();
      chk("t3_no_grant", 64'(o_rdy), 64'(0));
      chk("t3_arvld", 64'(lsu_axi_arvld), 64'(1));
    end
    axi_lsu_arrdy = 1'b1;
    cyc();

    // Outstanding throttle
    do_reset();
    axi_lsu_arrdy = 1'b1;
    set_req(1, 10'h300, 4'd15);
    req_arvld = 2'b10;
    cyc();
    set_req(1, 10'h304, 4'd1);
    cyc();
    chk("t4_outst15", 64'(dut.outst_q[1]), 64'(15));
    set_req(0, 10'h010, 4'd1);
    req_arvld = 2'b11;
    for (int n = 0; n < 4; n++) begin
      cyc();
      chk("t4_r1_blocked", 64'(o_rdy[1]), 64'(0));
    end
    req_arvld = 2'b10;
    axi_lsu_rvld = 1'b1; axi_lsu_rid = 4'h8; axi_lsu_rlast = 1'b1; req_rrdy = 2'b10;
    cyc();
    chk("t4_still_blocked", 64'(o_rdy), 64'(0));
    axi_lsu_rvld = 1'b0;
    cyc();
    chk("t4_grant", 64'(o_rdy), 64'(2'b10));

    // Response routing and same-cycle increment/decrement
    req_arvld = '0;
    axi_lsu_arrdy = 1'b0;
    axi_lsu_rvld = 1'b1; axi_lsu_rid = 4'h9; axi_lsu_rlast = 1'b1; req_rrdy = 2'b00;
    axi_lsu_rresp = 2'b10; axi_lsu_rdata = 64'hDEAD_BEEF_0123_4567;
    cyc();
    chk("t5_rvld", 64'(o_rvld), 64'(2'b10));
    chk("t5_rrdy", 64'(o_rrdy), 64'(0));
    chk("t5_hold", 64'(dut.outst_q[1]), 64'(14));
    req_rrdy = 2'b10;
    axi_lsu_arrdy = 1'b1;
    cyc();
    chk("t5_net", 64'(dut.outst_q[1]), 64'(14));

    // Underflow and bad index
    do_reset();
    axi_lsu_rvld = 1'b1; axi_lsu_rid = 4'h0; axi_lsu_rlast = 1'b1; req_rrdy = 2'b01;
    d3_i_rvld = 1'b1; d3_i_rid = 4'hC; d3_i_rlast = 1'b1;
    cyc();
    chk("t6_underflow_err", 64'(arb_err), 64'(1));
    chk("t6_bad_rvld", 64'(d3_rvld), 64'(0));
    chk("t6_bad_rrdy", 64'(d3_o_rrdy), 64'(1));
    chk("t6_bad_err", 64'(d3_err), 64'(1));
    axi_lsu_rvld = 1'b0;
    d3_i_rvld = 1'b0;

    // Asynchronous reset while BUSY
    set_req(0, 10'h3F0, 4'd1);
    req_arvld = 2'b01;
    axi_lsu_arrdy = 1'b0;
    cyc();
    chk("t6_busy", 64'(lsu_axi_arvld), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_arvld", 64'(lsu_axi_arvld), 64'(0));
    chk("t6_rst_arrdy", 64'(req_arrdy), 64'(0));
    chk("t6_rst_arid", 64'(lsu_axi_arid), 64'(0));
    chk("t6_rst_err", 64'(arb_err), 64'(0));
    chk("t6_rst_outst", 64'(dut.outst_q[0]), 64'(0));
    do_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      int j;
      for (int i = 0; i < NREQ; i++)
        if (last_rdy[i] || !req_arvld[i]) begin
          req_arvld[i] = $urandom_range(0, 2) != 0;
          set_req(i, AW'($urandom), 4'($urandom_range(0, 15)));
          req_arburst[i*2 +: 2] = 2'($urandom);
        end else if ($urandom_range(0, 9) == 0) req_arvld[i] = 1'b0;
      axi_lsu_arrdy = $urandom_range(0, 3) != 0;
      j = $urandom_range(0, NREQ - 1);
      axi_lsu_rvld = ($urandom_range(0, 1) != 0) && (m_outst[j] > 0);
      axi_lsu_rid = IDW'((j << SEQ_W) | $urandom_range(0, (1 << SEQ_W) - 1));
      axi_lsu_rlast = $urandom_range(0, 1) != 0;
      axi_lsu_rresp = 2'($urandom);
      axi_lsu_rdata = {$urandom, $urandom};
      req_rrdy = NREQ'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
